// File: rtl/dec_pol_seq.sv
// dec_pol_seq: registered SEL_W-to-2**SEL_W decoder with per-transaction polarity and auto SCAN mode
// Ports:
//    clk, rst_n         clock, asynchronous active-low reset
//    in_valid/in_ready  request handshake (ready only in IDLE)
//    in_sel, in_pol     line index and polarity (1 = one-hot, 0 = one-cold)
//    in_mode, abort     0 = DIRECT, 1 = SCAN; abort ends a SCAN early
//    d                  registered decoded lines
//    out_valid, busy    new active pattern pulse, SCAN in progress
//    done               pulse on normal SCAN completion
module dec_pol_seq #(
   parameter int SEL_W  = 2,
   parameter int DWELL  = 4,
   parameter int SWAP01 = 0,
   localparam int OUT_W = 2 ** SEL_W,
   localparam int CW    = DWELL > 1 ? $clog2(DWELL) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] in_sel,
   input  logic             in_pol,
   input  logic             in_mode,
   input  logic             abort,
   output logic [OUT_W-1:0] D,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);
   typedef enum logic {IDLE, SCAN} state_t;
   state_t state, state_n;
   logic [SEL_W-1:0] idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic pol_r, pol_n;
   logic [OUT_W-1:0] d_n;
   logic ov_n, done_n;
   // legacy ordering swaps lines 0 and 1 only
   function automatic logic [OUT_W-1:0] pat(input logic [SEL_W-1:0] i, input logic p);
      logic [SEL_W-1:0] m;
      m = (SWAP01 != 0 && (i >> 1) == '0) ? i ^ SEL_W'(1) : i;
      return p ? OUT_W'(1) << m : ~(OUT_W'(1) << m);
   endfunction
   assign in_ready = state == IDLE;
   assign busy = state == SCAN;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         idx <= '0;
         pol_r <= 1'b1;
         cnt <= '0;
         D <= '0;
         out_valid <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         pol_r <= pol_n;
         cnt <= cnt_n;
         D <= d_n;
         out_valid <= ov_n;
         done <= done_n;
      end
   always_comb begin
      state_n = state;
      idx_n = idx;
      pol_n = pol_r;
      cnt_n = cnt;
      d_n = D;
      ov_n = 1'b0;
      done_n = 1'b0;
      if (state == IDLE) begin
         if (in_valid) begin
            pol_n = in_pol;
            ov_n = 1'b1;
            idx_n = in_mode ? '0 : in_sel;
            d_n = pat(in_mode ? '0 : in_sel, in_pol);
            cnt_n = '0;
            state_n = in_mode ? SCAN : IDLE;
         end
      end else if (abort) begin
         d_n = {OUT_W{~pol_r}};
         state_n = IDLE;
      end else if (cnt == CW'(DWELL - 1)) begin
         cnt_n = '0;
         if (&idx) begin
            d_n = {OUT_W{~pol_r}};
            done_n = 1'b1;
            state_n = IDLE;
         end else begin
            idx_n = idx + SEL_W'(1);
            d_n = pat(idx + SEL_W'(1), pol_r);
            ov_n = 1'b1;
         end
      end else
         cnt_n = cnt + CW'(1);
   end
endmodule

// File: tb/tb_dec_pol_seq.sv
// tb_dec_pol_seq: directed table plus multi-cycle sequences for dec_pol_seq
module tb_dec_pol_seq;
   logic clk = 0, rst_n = 0;
   logic v0 = 0, v1 = 0, v2 = 0, pol = 1, mode = 0, abort = 0;
   logic [1:0] sel = 0;
   logic r0, r1, r2, ov0, ov1, ov2, b0, b1, b2, dn0, dn1, dn2;
   logic [3:0] d0, d1;
   logic [7:0] d2;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   dec_pol_seq #(.SEL_W(2), .DWELL(2), .SWAP01(0)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0),
      .in_sel(sel), .in_pol(pol), .in_mode(mode), .abort(abort), .D(d0), .out_valid(ov0), .busy(b0), .done(dn0));
   dec_pol_seq #(.SEL_W(2), .DWELL(2), .SWAP01(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
      .in_sel(sel), .in_pol(pol), .in_mode(mode), .abort(abort), .D(d1), .out_valid(ov1), .busy(b1), .done(dn1));
   dec_pol_seq #(.SEL_W(3), .DWELL(1), .SWAP01(0)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
      .in_sel({1'b0, sel}), .in_pol(pol), .in_mode(mode), .abort(abort), .D(d2), .out_valid(ov2), .busy(b2), .done(dn2));
   typedef struct {
      logic p;
      logic [1:0] s;
      logic [3:0] e0;
      logic [3:0] e1;
   } vec_t;
   vec_t tbl[8];
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask
   initial begin
      tbl[0] = '{1'b1, 2'd0, 4'b0001, 4'b0010};
      tbl[1] = '{1'b1, 2'd1, 4'b0010, 4'b0001};
      tbl[2] = '{1'b1, 2'd2, 4'b0100, 4'b0100};
      tbl[3] = '{1'b1, 2'd3, 4'b1000, 4'b1000};
      tbl[4] = '{1'b0, 2'd0, 4'b1110, 4'b1101};
      tbl[5] = '{1'b0, 2'd1, 4'b1101, 4'b1110};
      tbl[6] = '{1'b0, 2'd2, 4'b1011, 4'b1011};
      tbl[7] = '{1'b0, 2'd3, 4'b0111, 4'b0111};
      #12;
      chk("rst_d", d0, 0);
      chk("rst_busy", b0, 0);
      chk("rst_done", dn0, 0);
      chk("rst_ready", r0, 1);
      chk("rst_ov", ov0, 0);
      @(negedge clk);
      rst_n = 1;
      // back-to-back DIRECT accepts through the whole table
      for (int i = 0; i < 8; i++) begin
         pol = tbl[i].p;
         sel = tbl[i].s;
         v0 = 1;
         v1 = 1;
         @(negedge clk);
         chk($sformatf("dir_d0_%0d", i), d0, tbl[i].e0);
         chk($sformatf("dir_d1_%0d", i), d1, tbl[i].e1);
         chk($sformatf("dir_ov_%0d", i), ov0, 1);
      end
      v0 = 0;
      v1 = 0;
      pol = 1;
      sel = 0;
      abort = 1;
      @(negedge clk);
      chk("hold_d0", d0, 4'b0111);
      chk("hold_ov", ov0, 0);
      chk("idle_abort_ready", r0, 1);
      abort = 0;
      // SCAN pol=1 DWELL=2
      mode = 1;
      pol = 1;
      v0 = 1;
      @(negedge clk);
      v0 = 0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("scan_d_%0d", i), d0, 4'b0001 << (i / 2));
         chk($sformatf("scan_ov_%0d", i), ov0, (i % 2) == 0);
         chk($sformatf("scan_busy_%0d", i), b0, 1);
         chk($sformatf("scan_rdy_%0d", i), r0, 0);
         chk($sformatf("scan_done_%0d", i), dn0, 0);
         @(negedge clk);
      end
      chk("scan_end_d", d0, 0);
      chk("scan_end_done", dn0, 1);
      chk("scan_end_rdy", r0, 1);
      chk("scan_end_busy", b0, 0);
      @(negedge clk);
      chk("scan_done_pulse", dn0, 0);
      // SCAN pol=0 with abort on third cycle, in_valid held high
      pol = 0;
      sel = 3;
      v0 = 1;
      @(negedge clk);
      mode = 0;
      chk("ab_d_0", d0, 4'b1110);
      @(negedge clk);
      chk("ab_d_1", d0, 4'b1110);
      chk("ab_done_1", dn0, 0);
      @(negedge clk);
      chk("ab_d_2", d0, 4'b1101);
      chk("ab_ov_2", ov0, 1);
      abort = 1;
      @(negedge clk);
      chk("ab_d_end", d0, 4'b1111);
      chk("ab_done", dn0, 0);
      chk("ab_ov", ov0, 0);
      chk("ab_busy", b0, 0);
      v0 = 0;
      abort = 0;
      @(negedge clk);
      chk("ab_done_after", dn0, 0);
      // SEL_W=3 DWELL=1 scan
      mode = 1;
      pol = 1;
      v2 = 1;
      @(negedge clk);
      v2 = 0;
      mode = 0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("p_d_%0d", i), d2, 8'd1 << i);
         chk($sformatf("p_ov_%0d", i), ov2, 1);
         @(negedge clk);
      end
      chk("p_end_d", d2, 0);
      chk("p_end_done", dn2, 1);
      // asynchronous reset mid-scan
      mode = 1;
      pol = 1;
      v0 = 1;
      @(negedge clk);
      v0 = 0;
      mode = 0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("ar_d", d0, 0);
      chk("ar_busy", b0, 0);
      chk("ar_done", dn0, 0);
      chk("ar_rdy", r0, 1);
      @(negedge clk);
      rst_n = 1;
      sel = 2;
      v0 = 1;
      @(negedge clk);
      v0 = 0;
      chk("ar_accept_d", d0, 4'b0100);
      chk("ar_accept_ov", ov0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dec_pol_seq.md
Name: dec_pol_seq

Overview:
- Parametrised, registered N-to-2^N decoder with per-transaction output polarity. It is the successor to the fixed 2-to-4 polarity decoder.
- Adds a valid/ready input handshake, registered outputs, and an automatic SCAN mode that walks the active output through every line with a programmable dwell time.
- Adds an optional legacy D0/D1 swap for compatibility with the older figure ordering.
- Drives select/strobe lines for downstream banks whose enable polarity is chosen per transaction.

Parameters:
- SEL_W, 2, select width; OUT_W = 2**SEL_W output lines (SEL_W >= 1).
- DWELL, 4, cycles each line stays active in SCAN mode (>= 1).
- SWAP01, 0, 1 = swap the mapping of indices 0 and 1 (legacy ordering); 0 = natural ordering.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_sel  in  SEL_W  line index (DIRECT mode).
- in_pol  in  1  1 = active-high one-hot; 0 = active-low one-cold.
- in_mode  in  1  0 = DIRECT, 1 = SCAN.
- abort  in  1  terminate a SCAN in progress.
- D  out  OUT_W  registered decoded lines.
- out_valid  out  1  1-cycle pulse when D takes a new active pattern.
- busy  out  1  high while in SCAN state.
- done  out  1  1-cycle pulse when a SCAN completes normally.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: rst_n low immediately forces the reset values below.
- Reset values: state = IDLE, idx = 0, pol_r = 1, dwell_cnt = 0, D = all 0, out_valid = 0, done = 0, busy = 0.
- in_ready = (state == IDLE), combinational. busy = (state == SCAN).
- Line mapping: m = idx. If SWAP01 = 1, m = 0 maps to 1 and m = 1 maps to 0. Active pattern P = 1 << m.
  - Active pattern: D = pol_r ? P : ~P.
  - Inactive pattern: D = pol_r ? all 0 : all 1.
- States: IDLE, SCAN.
- IDLE, accept with in_mode = 0:
  - Next edge: idx <= in_sel, pol_r <= in_pol, D <= active pattern, out_valid = 1 for that cycle. State stays IDLE.
  - Latency is 1 cycle from accept edge to D. Back-to-back accepts every cycle are legal.
  - Between accepts, D holds its last value.
- IDLE, accept with in_mode = 1:
  - Next edge: pol_r <= in_pol, idx <= 0, dwell_cnt <= 0, D <= active pattern for index 0, out_valid = 1, state <= SCAN.
- SCAN:
  - dwell_cnt increments each cycle.
  - When dwell_cnt == DWELL-1 and idx < OUT_W-1: idx++, dwell_cnt <= 0, D <= next active pattern, out_valid = 1.
  - When dwell_cnt == DWELL-1 and idx == OUT_W-1: D <= inactive pattern, done = 1 for one cycle, state <= IDLE. in_ready is 1 in that same cycle.
  - Total scan length is OUT_W*DWELL cycles of active output.
- SCAN, abort = 1: next edge D <= inactive pattern, state <= IDLE, done stays 0, out_valid stays 0. Abort on the final dwell cycle also wins: no done pulse.
- in_valid while in_ready = 0 is ignored; the request is neither captured nor queued.
- abort in IDLE has no effect.
- Arithmetic:
  - dwell_cnt width is clog2(DWELL), minimum 1.
  - idx is SEL_W bits.
  - The idx increment never wraps; termination is at OUT_W-1.
- Reset mid-SCAN: the block returns to reset values immediately with no done pulse. The first edge after release may accept a request.

Test Plan:
- Reset/abort of reset: start a SCAN (SEL_W=2, DWELL=2, pol=1), drop rst_n mid-scan -> D=0000, busy=0, done=0, in_ready=1 asynchronously.
- DIRECT sweep, all 8 {pol, sel}, SWAP01=0:
  - pol=1, sel=2 -> D=0100; pol=0, sel=2 -> D=1011; pol=0, sel=3 -> D=0111.
  - out_valid pulses 1 cycle after each accept. Also check back-to-back accepts every cycle.
- SWAP01=1 DIRECT:
  - pol=1: sel=0 -> 0010, sel=1 -> 0001, sel=3 -> 1000.
  - pol=0: sel=0 -> 1101.
- SCAN, pol=1, DWELL=2:
  - D sequence over 8 cycles = 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, then 0000 with done=1.
  - busy=1 and in_ready=0 throughout. out_valid pulses on cycles 1, 3, 5, 7.
- SCAN, pol=0, abort asserted on the 3rd scan cycle:
  - D = 1110, 1110, 1101, then 1111 next edge; done never pulses.
  - in_valid held high during the scan does not change D or idx.
- Parametric: SEL_W=3, DWELL=1 SCAN -> 8 consecutive one-hot values 00000001..10000000, then 00000000 with done=1 exactly 8 cycles after the accept edge.
